// File: rtl/instr_decode_stage.sv
// Instruction decode stage with a two-entry output buffer (main + skid).
//
// Decodes the incoming RV32 instruction combinationally, classifies its format,
// extracts the sign-extended immediate and flags illegal encodings, then stores
// the result in a small FIFO. The oldest entry drives the outputs.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        upstream handshake; in_ready depends on registered state only
//   in_instr, in_pc          raw instruction word and its address
//   flush                    drops every held entry; wins over a same-cycle accept/pop
//   out_valid/out_ready      downstream handshake
//   out_pc .. out_funct7     oldest entry: address and raw bit fields
//   out_imm, out_type        immediate and format (R=0 I=1 S=2 B=3 U=4 J=5 none=7)
//   out_illegal              illegal-encoding flag
//   out_exc_cause            ILLEGAL_CAUSE for illegal entries, 0 otherwise
module instr_decode_stage #(
  parameter bit          ENABLE_M      = 1'b0,
  parameter bit          ENABLE_CSR    = 1'b1,
  parameter logic [31:0] ILLEGAL_CAUSE = 32'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [31:0] out_imm,
  output logic [2:0]  out_type,
  output logic        out_illegal,
  output logic [31:0] out_exc_cause
);

  localparam logic [2:0] TypeR    = 3'd0;
  localparam logic [2:0] TypeI    = 3'd1;
  localparam logic [2:0] TypeS    = 3'd2;
  localparam logic [2:0] TypeB    = 3'd3;
  localparam logic [2:0] TypeU    = 3'd4;
  localparam logic [2:0] TypeJ    = 3'd5;
  localparam logic [2:0] TypeNone = 3'd7;

  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7MulD = 7'b0000001;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        illegal;
  } entry_t;

  localparam entry_t EntryReset = '{
    pc: 32'd0, opcode: 7'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, funct3: 3'd0,
    funct7: 7'd0, imm: 32'd0, typ: TypeNone, illegal: 1'b0
  };

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   rdy_q;
  entry_t dec;
  logic   accept, pop;

  // Combinational decode of the incoming word.
  always_comb begin
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] ins;
    ins = in_instr;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];

    dec         = EntryReset;
    dec.pc      = in_pc;
    dec.opcode  = op;
    dec.rd      = ins[11:7];
    dec.rs1     = ins[19:15];
    dec.rs2     = ins[24:20];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.typ     = TypeNone;
    dec.imm     = 32'd0;
    dec.illegal = (ins[1:0] != 2'b11);

    case (op)
      OpOp: begin
        dec.typ = TypeR;
        if (f7 == F7Base) begin
          // every funct3 is defined
        end else if (f7 == F7Alt) begin
          if (!(f3 == 3'b000 || f3 == 3'b101)) dec.illegal = 1'b1;
        end else if (f7 == F7MulD) begin
          if (!ENABLE_M) dec.illegal = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OpLoad, OpImm, OpJalr, OpFence, OpSystem: begin
        dec.typ = TypeI;
        dec.imm = {{20{ins[31]}}, ins[31:20]};
        if (op == OpLoad && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) dec.illegal = 1'b1;
        if (op == OpJalr && f3 != 3'b000) dec.illegal = 1'b1;
        // Shift-immediates reuse the upper imm bits as funct7.
        if (op == OpImm && f3 == 3'b001 && f7 != F7Base) dec.illegal = 1'b1;
        if (op == OpImm && f3 == 3'b101 && !(f7 == F7Base || f7 == F7Alt)) dec.illegal = 1'b1;
        if (op == OpSystem && f3 != 3'b000 && !ENABLE_CSR) dec.illegal = 1'b1;
      end
      OpStore: begin
        dec.typ = TypeS;
        dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        if (f3 > 3'b010) dec.illegal = 1'b1;
      end
      OpBranch: begin
        dec.typ = TypeB;
        dec.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        if (f3 == 3'b010 || f3 == 3'b011) dec.illegal = 1'b1;
      end
      OpLui, OpAuipc: begin
        dec.typ = TypeU;
        dec.imm = {ins[31:12], 12'd0};
      end
      OpJal: begin
        dec.typ = TypeJ;
        dec.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: begin
        dec.typ     = TypeNone;
        dec.illegal = 1'b1;
      end
    endcase
  end

  // rdy_q keeps in_ready low during reset and for the first cycle until an edge sees rst low.
  assign in_ready  = rdy_q && (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = dec;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= EntryReset;
      skid_q  <= EntryReset;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= 1'b1;
    end
  end

  assign out_pc        = main_q.pc;
  assign out_opcode    = main_q.opcode;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_funct3    = main_q.funct3;
  assign out_funct7    = main_q.funct7;
  assign out_imm       = main_q.imm;
  assign out_type      = main_q.typ;
  assign out_illegal   = main_q.illegal;
  assign out_exc_cause = main_q.illegal ? ILLEGAL_CAUSE : 32'd0;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic [2:0]  out_type;
  logic        out_illegal;
  logic [31:0] out_exc_cause;

  // Second instance with the M extension enabled, fed the same stimulus.
  logic        in_ready_m, out_valid_m, out_illegal_m;
  logic [31:0] out_pc_m, out_imm_m, out_exc_cause_m;
  logic [6:0]  out_opcode_m, out_funct7_m;
  logic [4:0]  out_rd_m, out_rs1_m, out_rs2_m;
  logic [2:0]  out_funct3_m, out_type_m;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_type(out_type), .out_illegal(out_illegal), .out_exc_cause(out_exc_cause)
  );

  instr_decode_stage #(.ENABLE_M(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready_m), .flush(flush), .out_ready(out_ready), .out_valid(out_valid_m),
    .out_pc(out_pc_m), .out_opcode(out_opcode_m), .out_rd(out_rd_m), .out_rs1(out_rs1_m),
    .out_rs2(out_rs2_m), .out_funct3(out_funct3_m), .out_funct7(out_funct7_m),
    .out_imm(out_imm_m), .out_type(out_type_m), .out_illegal(out_illegal_m),
    .out_exc_cause(out_exc_cause_m)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  typ;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
    logic        ill_m;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   dmy;

  function automatic exp_t mk(input logic [31:0] instr, input logic [2:0] typ,
                              input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic ill, ill_m);
    exp_t e;
    e.instr = instr; e.pc = 32'd0; e.typ = typ; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.f3 = f3; e.f7 = f7; e.imm = imm; e.ill = ill; e.ill_m = ill_m;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_out", {31'd0, out_valid}, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pc", out_pc, e.pc);
      chk("opcode", {25'd0, out_opcode}, {25'd0, e.instr[6:0]});
      chk("type", {29'd0, out_type}, {29'd0, e.typ});
      chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
      chk("rs1", {27'd0, out_rs1}, {27'd0, e.rs1});
      chk("rs2", {27'd0, out_rs2}, {27'd0, e.rs2});
      chk("funct3", {29'd0, out_funct3}, {29'd0, e.f3});
      chk("funct7", {25'd0, out_funct7}, {25'd0, e.f7});
      chk("imm", out_imm, e.imm);
      chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      chk("exc_cause", out_exc_cause, e.ill ? 32'd2 : 32'd0);
      chk("m_valid", {31'd0, out_valid_m}, 32'd1);
      chk("m_illegal", {31'd0, out_illegal_m}, {31'd0, e.ill_m});
    end
  endtask

  // Evaluates this cycle's handshakes just after the falling edge, then advances a cycle.
  task automatic tick(output bit acc);
    acc = 1'b0;
    #1;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) pop_check();
      if (in_valid && in_ready) begin
        sb.push_back(cur);
        acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic present(input logic [31:0] pc, input exp_t e);
    cur = e;
    cur.pc = pc;
    in_valid = 1'b1;
    in_instr = e.instr;
    in_pc = pc;
  endtask

  task automatic send(input logic [31:0] pc, input exp_t e);
    bit acc;
    int n;
    present(pc, e);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    in_valid = 1'b0;
    n_checks++;
    assert (acc) n_pass++;
    else $error("FAIL accept_timeout: pc 0x%08h observed no accept, required accept within 20 cycles", pc);
  endtask

  exp_t e_addi, e_beq, e_lui, e_mul, e_zero, e_sw, e_sbad, e_jal, e_slli, e_csr;

  initial begin
    e_addi = mk(32'hFFF00093, 3'd1, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0, 1'b0);
    e_beq  = mk(32'hFE000EE3, 3'd3, 5'd29, 5'd0, 5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0, 1'b0);
    e_lui  = mk(32'h123452B7, 3'd4, 5'd5,  5'd8, 5'd3,  3'd5, 7'h09, 32'h12345000, 1'b0, 1'b0);
    e_mul  = mk(32'h022081B3, 3'd0, 5'd3,  5'd1, 5'd2,  3'd0, 7'h01, 32'h00000000, 1'b1, 1'b0);
    e_zero = mk(32'h00000000, 3'd7, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h00000000, 1'b1, 1'b1);
    e_sw   = mk(32'hFE20AC23, 3'd2, 5'd24, 5'd1, 5'd2,  3'd2, 7'h7F, 32'hFFFFFFF8, 1'b0, 1'b0);
    e_sbad = mk(32'h00003023, 3'd2, 5'd0,  5'd0, 5'd0,  3'd3, 7'h00, 32'h00000000, 1'b1, 1'b1);
    e_jal  = mk(32'h008000EF, 3'd5, 5'd1,  5'd0, 5'd8,  3'd0, 7'h00, 32'h00000008, 1'b0, 1'b0);
    e_slli = mk(32'h40101093, 3'd1, 5'd1,  5'd0, 5'd1,  3'd1, 7'h20, 32'h00000401, 1'b1, 1'b1);
    e_csr  = mk(32'h30002573, 3'd1, 5'd10, 5'd0, 5'd0,  3'd2, 7'h18, 32'h00000300, 1'b0, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_type", {29'd0, out_type}, 32'd7);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_exc_cause", out_exc_cause, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("release_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #1 chk("release_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Single transaction: one-cycle latency.
    out_ready = 1'b1;
    send(32'h100, e_addi);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    tick(dmy);
    #1 chk("drained_out_valid", {31'd0, out_valid}, 32'd0);

    // Streaming back-to-back: accept and pop in the same cycle.
    send(32'h104, e_beq);
    send(32'h108, e_lui);
    send(32'h10C, e_mul);
    send(32'h110, e_zero);
    send(32'h114, e_sw);
    send(32'h118, e_sbad);
    send(32'h11C, e_jal);
    send(32'h120, e_slli);
    send(32'h124, e_csr);
    repeat (3) tick(dmy);
    chk("stream_sb_empty", sb.size(), 32'd0);

    // Stall: two accepted, third held off, outputs stable, then drain in order.
    out_ready = 1'b0;
    present(32'h200, e_addi); tick(dmy);
    present(32'h204, e_lui);  tick(dmy);
    present(32'h208, e_jal);
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_out_pc", out_pc, 32'h200);
    tick(dmy);
    chk("stall_hold_pc", out_pc, 32'h200);
    chk("stall_hold_imm", out_imm, 32'hFFFFFFFF);
    chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick(dmy);
    #1 chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    tick(dmy);
    in_valid = 1'b0;
    repeat (2) tick(dmy);
    chk("stall_sb_empty", sb.size(), 32'd0);

    // Flush while full, with same-cycle accept and pop requested.
    out_ready = 1'b0;
    send(32'h300, e_beq);
    send(32'h304, e_sw);
    #1 chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; out_ready = 1'b1;
    present(32'h308, e_csr);
    tick(dmy);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) tick(dmy);

    // Asynchronous reset while one entry is held.
    out_ready = 1'b0;
    send(32'h400, e_lui);
    #1 chk("one_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("async_rst_out_type", {29'd0, out_type}, 32'd7);
    chk("async_rst_out_pc", out_pc, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick(dmy);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    send(32'h500, e_csr);
    repeat (2) tick(dmy);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
